// File: rtl/UART_pkg.sv
// Shared UART types: byte-transmitter and word-sequencer state encodings,
// parity mode encodings and the parity helper.
package UART_pkg;

  // Byte transmitter states (3-bit so monitors can observe undefined codes).
  typedef enum logic [2:0] {
    IDLE_S   = 3'd0,
    START_S  = 3'd1,
    DATA_S   = 3'd2,
    PARITY_S = 3'd3,
    STOP_S   = 3'd4
  } tx_state_t;

  // Word-level sequencer states (one byte of a 32-bit word per send).
  typedef enum logic [1:0] {
    W_IDLE_S = 2'd0,
    W_SEND_S = 2'd1,
    W_WAIT_S = 2'd2,
    W_DONE_S = 2'd3
  } word_state_t;

  // Parity modes.
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Parity bit for a byte: even mode makes the total count of ones even,
  // odd mode makes it odd.
  function automatic logic parity_of(input logic [7:0] d, input int mode);
    return (mode == PAR_ODD) ? ~(^d) : ^d;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: bit_end is high in the last cycle of each BAUD_DIV-cycle
// bit period. The count restarts on clr (state change) and wraps at bit end.
module uart_baud_counter #(
  parameter int BAUD_DIV = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);

  localparam int W = $clog2(BAUD_DIV);
  localparam logic [W-1:0] LAST = W'(BAUD_DIV - 1);

  logic [W-1:0] cnt;

  // Count cycles within the bit; restart on clear or at the end of the bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign bit_end = (cnt == LAST);

endmodule

// File: rtl/uart_byte_tx.sv
// Byte-level UART transmitter: start bit, 8 data bits LSB first, optional
// parity bit and one stop bit on a registered, idle-high tx line.
module uart_byte_tx
  import UART_pkg::*;
#(
  parameter int BAUD_DIV = 434,
  parameter int PARITY   = PAR_NONE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_send,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_fsm_in_STOP_S,
  output tx_state_t  tx_state_out
);

  if (BAUD_DIV < 2) begin : g_bad_baud_div
    $error("uart_byte_tx: BAUD_DIV must be >= 2");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
    $error("uart_byte_tx: PARITY must be 0 (none), 1 (even) or 2 (odd)");
  end

  tx_state_t  state, state_nx;
  logic [7:0] shift_q, shift_nx;
  logic [2:0] idx_q, idx_nx;
  logic       par_q, par_nx;
  logic       tx_nx;
  logic       bit_end;
  logic       clr;

  // Counter restarts whenever the state changes, so every bit is BAUD_DIV long.
  assign clr = (state_nx != state);

  uart_baud_counter #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .bit_end(bit_end)
  );

  // Next-state, shift register, bit index and parity accumulator.
  always_comb begin
    state_nx = state;
    shift_nx = shift_q;
    idx_nx   = idx_q;
    par_nx   = par_q;
    unique case (state)
      IDLE_S: begin
        if (tx_send) begin
          state_nx = START_S;
          shift_nx = tx_data;
          idx_nx   = '0;
          par_nx   = (PARITY == PAR_NONE) ? 1'b0 : parity_of(tx_data, PARITY);
        end
      end
      START_S: begin
        if (bit_end) state_nx = DATA_S;
      end
      DATA_S: begin
        if (bit_end) begin
          shift_nx = {1'b0, shift_q[7:1]};
          idx_nx   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_nx = (PARITY != PAR_NONE) ? PARITY_S : STOP_S;
        end
      end
      PARITY_S: begin
        if (bit_end) state_nx = STOP_S;
      end
      STOP_S: begin
        if (bit_end) state_nx = IDLE_S;
      end
      default: state_nx = IDLE_S;
    endcase
  end

  // Line level is decoded from the next state so the registered tx changes in
  // the same cycle the state does.
  always_comb begin
    tx_nx = 1'b1;
    case (state_nx)
      IDLE_S:   tx_nx = 1'b1;
      START_S:  tx_nx = 1'b0;
      DATA_S:   tx_nx = shift_nx[0];
      PARITY_S: tx_nx = par_nx;
      STOP_S:   tx_nx = 1'b1;
      default:  tx_nx = 1'b1;
    endcase
  end

  // State, datapath and line registers; reset drops any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE_S;
      shift_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nx;
      shift_q <= shift_nx;
      idx_q   <= idx_nx;
      par_q   <= par_nx;
      tx      <= tx_nx;
    end
  end

  assign tx_busy          = (state != IDLE_S);
  assign tx_fsm_in_STOP_S = (state == STOP_S) && bit_end;
  assign tx_state_out     = state;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx: four instances (no/even/odd parity at BAUD_DIV=4,
// no parity at BAUD_DIV=434). Each frame's line waveform is recorded and
// decoded like a receiver, then compared with a frame model built from the
// byte and the parity mode.
module tb_uart_byte_tx;
  import UART_pkg::*;

  localparam int NU = 4;
  localparam int BD [NU] = '{4, 4, 4, 434};
  localparam int PR [NU] = '{0, 1, 2, 0};

  logic       clk = 1'b0;
  logic       rst;
  logic       send  [NU];
  logic [7:0] data  [NU];
  logic       txw   [NU];
  logic       busy  [NU];
  logic       stp   [NU];
  tx_state_t  st    [NU];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    uart_byte_tx #(
      .BAUD_DIV(BD[g]),
      .PARITY  (PR[g])
    ) u_dut (
      .clk             (clk),
      .rst             (rst),
      .tx_send         (send[g]),
      .tx_data         (data[g]),
      .tx              (txw[g]),
      .tx_busy         (busy[g]),
      .tx_fsm_in_STOP_S(stp[g]),
      .tx_state_out    (st[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Send byte d on unit u starting in the current (idle) cycle, record the
  // outputs for the F+1 following cycles and check them against the model.
  // poke_at != 0 drives a tx_send of 8'hFF in that frame cycle; hold keeps
  // tx_send high throughout so the next call is accepted back-to-back.
  task automatic frame(input int u, input logic [7:0] d, input int poke_at, input bit hold);
    int bd = BD[u];
    int pm = PR[u];
    int nb = (pm != 0) ? 11 : 10;
    int f  = nb * bd;
    int ones = $countones(d);
    logic exp_par;
    logic lvl [$];
    logic sp  [$];
    logic bs  [$];
    tx_state_t sq [$];
    logic [7:0] dec;
    int werr = 0;
    int stops = 0;
    int stop_at = -1;
    int busy_cnt = 0;
    string t;

    exp_par = (pm == 1) ? logic'(ones % 2) : logic'(1 - (ones % 2));
    t = $sformatf("u%0d d=%02h", u, d);

    send[u] = 1'b1;
    data[u] = d;
    for (int c = 1; c <= f + 1; c++) begin
      tick();
      lvl.push_back(txw[u]);
      sp.push_back(stp[u]);
      bs.push_back(busy[u]);
      sq.push_back(st[u]);
      if (c == 1) begin
        if (!hold) send[u] = 1'b0;
        data[u] = 8'($urandom);
      end
      if (poke_at != 0 && c == poke_at) begin
        send[u] = 1'b1;
        data[u] = 8'hFF;
      end
      if (poke_at != 0 && c == poke_at + 1) begin
        send[u] = hold;
        data[u] = 8'($urandom);
      end
    end

    for (int k = 0; k < nb; k++)
      for (int j = 0; j < bd; j++)
        if (lvl[k*bd + j] !== lvl[k*bd + bd/2]) werr++;
    for (int k = 0; k < 8; k++) dec[k] = lvl[(1 + k)*bd + bd/2];
    for (int c = 0; c <= f; c++) begin
      if (sp[c] === 1'b1) begin
        stops++;
        stop_at = c + 1;
      end
      if (bs[c] === 1'b1) busy_cnt++;
    end

    check({t, " start_bit"}, lvl[bd/2], 1'b0);
    check({t, " data_byte"}, dec, d);
    if (pm != 0) check({t, " parity_bit"}, lvl[9*bd + bd/2], exp_par);
    check({t, " stop_bit"}, lvl[(nb - 1)*bd + bd/2], 1'b1);
    check({t, " bit_width_errs"}, werr, 0);
    check({t, " stop_pulse_cycle"}, stop_at, f);
    check({t, " stop_pulse_count"}, stops, 1);
    check({t, " busy_cycles"}, busy_cnt, f);
    check({t, " state_first"}, sq[0], START_S);
    check({t, " state_after"}, sq[f], IDLE_S);
  endtask

  initial begin
    rst = 1'b0;
    for (int u = 0; u < NU; u++) begin
      send[u] = 1'b0;
      data[u] = 8'h00;
    end
    repeat (3) tick();
    for (int u = 0; u < NU; u++) begin
      check($sformatf("u%0d reset tx", u), txw[u], 1'b1);
      check($sformatf("u%0d reset busy", u), busy[u], 1'b0);
      check($sformatf("u%0d reset stop", u), stp[u], 1'b0);
      check($sformatf("u%0d reset state", u), st[u], IDLE_S);
    end
    rst = 1'b1;
    tick();

    // Basic frame, then even and odd parity.
    frame(0, 8'hA5, 0, 0);
    frame(1, 8'h07, 0, 0);
    frame(2, 8'h07, 0, 0);

    // Sequencer-style back-to-back: each request in the cycle after the stop pulse.
    frame(0, 8'h11, 0, 0);
    frame(0, 8'h22, 0, 0);
    frame(0, 8'h33, 0, 0);
    frame(0, 8'h44, 0, 0);

    // tx_send held high across frames.
    frame(0, 8'($urandom), 0, 1);
    frame(0, 8'($urandom), 0, 1);
    frame(0, 8'($urandom), 0, 0);

    // Request while busy is ignored; tx_data churns mid-frame.
    frame(0, 8'h00, 13, 0);
    frame(1, 8'($urandom), 2 + int'($urandom_range(40)), 0);
    frame(2, 8'($urandom), 2 + int'($urandom_range(40)), 0);

    // Random bytes on every small-divider unit.
    for (int i = 0; i < 3; i++)
      for (int u = 0; u < 3; u++)
        frame(u, 8'($urandom), (i == 1) ? 2 + int'($urandom_range(30)) : 0, 0);

    // Reset in the middle of DATA_S: line and state return asynchronously.
    send[0] = 1'b1;
    data[0] = 8'h00;
    tick();
    send[0] = 1'b0;
    repeat (8) tick();
    check("mid state before reset", st[0], DATA_S);
    check("mid tx before reset", txw[0], 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("async reset tx", txw[0], 1'b1);
    check("async reset state", st[0], IDLE_S);
    check("async reset busy", busy[0], 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    frame(0, 8'h5A, 0, 0);

    // Large divider.
    frame(3, 8'hA5, 0, 0);
    frame(3, 8'($urandom), 1000, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
